// File: rtl/twos_comp_pkg.sv
// Shared constants and word types for the two's-complement to sign-magnitude converter.
package twos_comp_pkg;

  // Default operand / magnitude width.
  localparam int DEFAULT_WIDTH = 13;

  // Most-negative operand at the default width: only the MSB set.
  localparam logic [DEFAULT_WIDTH-1:0] MOST_NEG = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};

  // Operand word (two's complement) and magnitude word (unsigned).
  typedef logic [DEFAULT_WIDTH-1:0] operand_t;
  typedef logic [DEFAULT_WIDTH-1:0] mag_t;

endpackage : twos_comp_pkg

// File: rtl/abs_value.sv
// Combinational absolute value: splits a two's-complement word into sign and
// unsigned magnitude, and flags the most-negative pattern. The most-negative
// input has no positive counterpart in signed form, but its magnitude
// (2^(WIDTH-1)) fits exactly in WIDTH unsigned bits, so no saturation is needed.
module abs_value
  import twos_comp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] d,
  output logic             sign,
  output logic [WIDTH-1:0] mag,
  output logic             max_neg,
  output logic             zero
);

  localparam logic [WIDTH-1:0] NEG_LIMIT = {1'b1, {(WIDTH-1){1'b0}}};

  // Negate only when the sign bit is set; zero therefore never gets a sign.
  always_comb begin
    sign    = d[WIDTH-1];
    mag     = sign ? (~d + WIDTH'(1)) : d;
    max_neg = (d == NEG_LIMIT);
    zero    = (d == '0);
  end

endmodule : abs_value

// File: rtl/twos_comp_to_sm.sv
// Registered two's-complement to sign-magnitude converter, one result per cycle,
// latency one cycle. Output registers hold their value while in_valid is low;
// only out_valid drops.
// Optional feature: define TWOS_COMP_TO_SM_ZERO_FLAG_EN to add the registered
// is_zero output.
module twos_comp_to_sm
  import twos_comp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  input  logic             in_valid,
  output logic             S,
  output logic [WIDTH-1:0] Mag,
  output logic             out_valid,
  output logic             max_neg
`ifdef TWOS_COMP_TO_SM_ZERO_FLAG_EN
  ,
  output logic             is_zero
`endif
);

  logic             abs_sign;
  logic [WIDTH-1:0] abs_mag;
  logic             abs_max_neg;
  logic             abs_zero;

  logic             s_q, s_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic             vld_q, vld_d;
  logic             mn_q, mn_d;

  abs_value #(.WIDTH(WIDTH)) u_abs (
    .d       (D),
    .sign    (abs_sign),
    .mag     (abs_mag),
    .max_neg (abs_max_neg),
    .zero    (abs_zero)
  );

  // Load a fresh result on a valid beat; otherwise hold data and drop valid.
  always_comb begin
    s_d   = s_q;
    mag_d = mag_q;
    mn_d  = mn_q;
    vld_d = 1'b0;
    if (in_valid) begin
      s_d   = abs_sign;
      mag_d = abs_mag;
      mn_d  = abs_max_neg;
      vld_d = 1'b1;
    end
  end

  // Output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q   <= 1'b0;
      mag_q <= '0;
      vld_q <= 1'b0;
      mn_q  <= 1'b0;
    end else begin
      s_q   <= s_d;
      mag_q <= mag_d;
      vld_q <= vld_d;
      mn_q  <= mn_d;
    end
  end

  assign S         = s_q;
  assign Mag       = mag_q;
  assign out_valid = vld_q;
  assign max_neg   = mn_q;

`ifdef TWOS_COMP_TO_SM_ZERO_FLAG_EN
  logic zero_q, zero_d;

  // Zero flag follows the same load/hold rule as the other result fields.
  always_comb begin
    zero_d = zero_q;
    if (in_valid) zero_d = abs_zero;
  end

  // Zero flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) zero_q <= 1'b0;
    else       zero_q <= zero_d;
  end

  assign is_zero = zero_q;
`else
  // Zero detection is only consumed when the flag is built in.
  logic unused_zero;
  assign unused_zero = abs_zero;
`endif

endmodule : twos_comp_to_sm

// File: tb/tb_twos_comp_to_sm.sv
// Self-checking bench for twos_comp_to_sm: directed corner cases, reset
// behaviour and a randomized stream compared against an arithmetic model.
module tb_twos_comp_to_sm;

  localparam int W = 13;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] D;
  logic         in_valid;
  logic         S;
  logic [W-1:0] Mag;
  logic         out_valid;
  logic         max_neg;
`ifdef TWOS_COMP_TO_SM_ZERO_FLAG_EN
  logic         is_zero;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (what the outputs should currently show).
  logic         exp_s, exp_vld, exp_mn, exp_zero;
  logic [W-1:0] exp_mag;

  twos_comp_to_sm #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .D         (D),
    .in_valid  (in_valid),
    .S         (S),
    .Mag       (Mag),
    .out_valid (out_valid),
    .max_neg   (max_neg)
`ifdef TWOS_COMP_TO_SM_ZERO_FLAG_EN
    ,
    .is_zero   (is_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".S"},         64'(S),         64'(exp_s));
    chk({tag, ".Mag"},       64'(Mag),       64'(exp_mag));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(exp_vld));
    chk({tag, ".max_neg"},   64'(max_neg),   64'(exp_mn));
`ifdef TWOS_COMP_TO_SM_ZERO_FLAG_EN
    chk({tag, ".is_zero"},   64'(is_zero),   64'(exp_zero));
`endif
  endtask

  // Model of one clock edge, from the arithmetic definition of |D|.
  task automatic model_edge(input logic [W-1:0] d, input logic v);
    longint sv;
    if (!v) begin
      exp_vld = 1'b0;
      return;
    end
    sv = longint'($signed(d));
    exp_vld  = 1'b1;
    exp_s    = (sv < 0);
    exp_mag  = W'((sv < 0) ? -sv : sv);
    exp_mn   = (sv == -(longint'(1) << (W - 1)));
    exp_zero = (sv == 0);
  endtask

  // Drive one beat, let the edge happen, check 1 time unit later.
  task automatic apply(input logic [W-1:0] d, input logic v, input string tag);
    D = d;
    in_valid = v;
    @(posedge clk);
    model_edge(d, v);
    #1;
    chk_all(tag);
  endtask

  task automatic model_reset();
    exp_s = 1'b0; exp_mag = '0; exp_vld = 1'b0; exp_mn = 1'b0; exp_zero = 1'b0;
  endtask

  initial begin
    logic [W-1:0] rd;
    logic         rv;

    // Reset takes effect before any clock edge.
    reset = 1'b1; D = '0; in_valid = 1'b0;
    model_reset();
    #1;
    chk_all("reset_init");
    @(posedge clk); #1;
    chk_all("reset_held");
    #2 reset = 1'b0;

    // Directed corner cases.
    apply(13'h0000, 1'b1, "zero");
    apply(13'h1FFF, 1'b1, "minus1");
    apply(13'h1001, 1'b1, "minus4095");
    apply(13'h0FFF, 1'b1, "plus4095");
    apply(13'h1000, 1'b1, "most_neg");
    apply(13'h0001, 1'b1, "plus1_after_mn");

    // Back-to-back stream then idle: data held, valid drops.
    apply(13'h0005, 1'b1, "stream_p5");
    apply(13'h1FFB, 1'b1, "stream_m5");
    apply(13'h0123, 1'b0, "stream_idle");
    chk("stream_hold_S",   64'(S),   64'(1));
    chk("stream_hold_Mag", 64'(Mag), 64'(5));
    apply(13'h1000, 1'b0, "idle_ignores_D");

    // Mid-cycle reset while a result is valid clears outputs before any edge.
    apply(13'h1000, 1'b1, "pre_reset_mn");
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk_all("async_reset");
    // in_valid is ignored while reset is held.
    D = 13'h1234; in_valid = 1'b1;
    @(posedge clk); #1;
    chk_all("reset_ignores_valid");
    #2 reset = 1'b0; in_valid = 1'b0;
    apply(13'h0777, 1'b0, "post_reset_idle");
    apply(13'h1FFE, 1'b1, "post_reset_first");

    // Randomized stream, biased towards corner patterns.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0:       rd = 13'h1000;
        1:       rd = 13'h0000;
        2:       rd = 13'h1FFF;
        default: rd = W'($urandom);
      endcase
      rv = ($urandom_range(0, 3) != 0);
      apply(rd, rv, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_twos_comp_to_sm

// File: doc/twos_comp_to_sm.md
TWOS_COMP_TO_SM -- requirements
Module: twos_comp_to_sm

Interface
REQ-001 SHALL have parameter WIDTH, default 13, giving the bit width of input word D and of output magnitude Mag (legal range 2..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port D, input, WIDTH bits: two's-complement operand.
REQ-005 SHALL have port in_valid, input, 1 bit: D is sampled on a rising clk edge only while in_valid=1.
REQ-006 SHALL have port S, output, 1 bit: registered sign, 1 means negative.
REQ-007 SHALL have port Mag, output, WIDTH bits: registered unsigned magnitude.
REQ-008 SHALL have port out_valid, output, 1 bit: S and Mag hold a result produced from a sampled D.
REQ-009 SHALL have port max_neg, output, 1 bit: the registered result came from the most-negative input.

Function
REQ-010 On a rising edge with in_valid=1, SHALL load S=D[WIDTH-1], Mag=|D|, out_valid=1; latency exactly 1 cycle; one new result per cycle, no stalls.
REQ-011 |D| SHALL be D when D[WIDTH-1]=0, else (~D)+1 truncated to WIDTH bits.
REQ-012 Zero input SHALL give S=0, Mag=0; negative zero SHALL never be produced.
REQ-013 Most-negative input (only MSB set, 13'h1000 at default width) SHALL give S=1, Mag=13'h1000 (exact, unsigned 4096), max_neg=1; no saturation, no error.
REQ-014 max_neg SHALL be 0 for every other sampled input.
REQ-015 On a rising edge with in_valid=0, SHALL clear out_valid to 0 and hold S, Mag and max_neg unchanged.
REQ-016 Outputs SHALL depend only on registered state; no combinational path from D or in_valid to any output.
REQ-017 Assertion of reset at any time, including mid-stream, SHALL discard any in-flight result; the first valid result after release SHALL come from the first edge with in_valid=1 after release.

Reset
REQ-018 While reset=1, SHALL force S=0, Mag=0, out_valid=0, max_neg=0 immediately, without waiting for clk.
REQ-019 SHALL ignore in_valid on any edge where reset=1.

Configuration
REQ-020 Macro TWOS_COMP_TO_SM_ZERO_FLAG_EN, when defined, SHALL add output port is_zero (1 bit), registered alongside S and Mag, set to 1 exactly when the sampled D is all zeros, held on in_valid=0, and reset to 0.
REQ-021 Without TWOS_COMP_TO_SM_ZERO_FLAG_EN, is_zero SHALL NOT exist and all other behaviour SHALL be identical.

Structure
REQ-022 Package twos_comp_pkg SHALL hold the default width constant (13), the derived constant for the most-negative pattern, and typedefs for the operand word and the magnitude word.
REQ-023 SHALL contain one combinational sub-module abs_value (WIDTH-parameterised; outputs sign, magnitude, max-neg indication), instantiated once, feeding the output registers.

Verification
REQ-024 D=13'h0000, in_valid=1 -> next edge: S=0, Mag=13'h0000, out_valid=1, max_neg=0 (is_zero=1 when enabled).
REQ-025 D=13'h1FFF (-1) -> S=1, Mag=13'h0001, max_neg=0.
REQ-026 D=13'h1001 (-4095) -> S=1, Mag=13'h0FFF; D=13'h0FFF (+4095) -> S=0, Mag=13'h0FFF.
REQ-027 D=13'h1000 (-4096) -> S=1, Mag=13'h1000, max_neg=1.
REQ-028 Back-to-back stream 13'h0005, 13'h1FFB, then in_valid=0 -> results (0,5), (1,5) on consecutive cycles, then out_valid=0 with S=1, Mag=13'h0005 held.
REQ-029 Reset asserted between clock edges while out_valid=1 -> outputs clear to 0 before the next edge; after release, no out_valid until in_valid=1 is sampled.
